// File: rtl/bcd_sub_arb.sv
// Two-port round-robin front end for a shared combinational 3-digit BCD subtractor.
// The result (magnitude, sign, owner, error) is held on a valid/ready port until it is consumed.

module bcd_digit_sub (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);
  logic [4:0] t;

  always_comb begin
    t    = {1'b0, x} - {1'b0, y} - {4'b0, bin};
    bout = t[4];
    d    = t[4] ? (t[3:0] + 4'd10) : t[3:0];
  end
endmodule

module bcd_sub #(
  parameter int NUM_DIG = 3
) (
  input  logic [NUM_DIG-1:0][3:0] a,
  input  logic [NUM_DIG-1:0][3:0] b,
  output logic [NUM_DIG-1:0][3:0] diff,
  output logic                    negative
);
  logic [NUM_DIG-1:0][3:0] d_ab, d_ba;
  logic [NUM_DIG:0]        bw_ab, bw_ba;

  assign bw_ab[0] = 1'b0;
  assign bw_ba[0] = 1'b0;

  // Both directions are computed; the borrow out of a-b picks the magnitude.
  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
    bcd_digit_sub u_ab (.x(a[g]), .y(b[g]), .bin(bw_ab[g]), .d(d_ab[g]), .bout(bw_ab[g+1]));
    bcd_digit_sub u_ba (.x(b[g]), .y(a[g]), .bin(bw_ba[g]), .d(d_ba[g]), .bout(bw_ba[g+1]));
  end

  // b>=a flags negative, so equal operands come out negative with zero magnitude.
  assign negative = ~bw_ba[NUM_DIG];
  assign diff     = bw_ab[NUM_DIG] ? d_ba : d_ab;
endmodule

module bcd_sub_arb #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [11:0]      req0_a,
  input  logic [11:0]      req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [11:0]      req1_a,
  input  logic [11:0]      req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [11:0]      res_diff,
  output logic             res_negative,
  output logic             res_id,
  output logic             res_error,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t      state, state_nxt;
  logic        last_grant, grant, grant_vld;
  logic [11:0] op_a, op_b;
  logic        op_id;
  logic [11:0] sub_diff;
  logic        sub_neg, op_err;

  bcd_sub #(.NUM_DIG(3)) u_sub (.a(op_a), .b(op_b), .diff(sub_diff), .negative(sub_neg));

  always_comb begin
    op_err = 1'b0;
    for (int i = 0; i < 3; i++)
      if (op_a[i*4 +: 4] > 4'd9 || op_b[i*4 +: 4] > 4'd9) op_err = 1'b1;
  end

  always_comb begin
    grant_vld = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else                          grant = ~req0_valid;
  end

  assign req0_ready = (state == IDLE) && grant_vld && !grant;
  assign req1_ready = (state == IDLE) && grant_vld &&  grant;
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = CALC;
      CALC:    state_nxt = HOLD;
      HOLD:    if (res_valid && res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      op_a         <= '0;
      op_b         <= '0;
      op_id        <= 1'b0;
      res_valid    <= 1'b0;
      res_diff     <= '0;
      res_negative <= 1'b0;
      res_id       <= 1'b0;
      res_error    <= 1'b0;
      op_count     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (grant_vld) begin
          op_a       <= grant ? req1_a : req0_a;
          op_b       <= grant ? req1_b : req0_b;
          op_id      <= grant;
          last_grant <= grant;
        end
        CALC: begin
          res_valid    <= 1'b1;
          res_id       <= op_id;
          res_error    <= op_err;
          res_diff     <= op_err ? 12'h000 : sub_diff;
          res_negative <= !op_err && (op_a != op_b) && sub_neg;
        end
        HOLD: if (res_valid && res_ready) begin
          res_valid <= 1'b0;
          op_count  <= op_count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_sub_arb.sv
// Bench for bcd_sub_arb: directed cases plus random transactions checked against
// an integer-arithmetic model of BCD subtraction and the round-robin grant rules.

module tb_bcd_sub_arb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [11:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_ready, req1_ready;
  logic        res_valid, res_ready = 1'b1;
  logic [11:0] res_diff;
  logic        res_negative, res_id, res_error, busy;
  logic [15:0] op_count;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  bcd_sub_arb #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_diff(res_diff),
    .res_negative(res_negative), .res_id(res_id), .res_error(res_error),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {error, negative, diff} from decimal arithmetic on the digit values.
  function automatic logic [13:0] model(input logic [11:0] a, input logic [11:0] b);
    int av, bv, m;
    logic [3:0] an, bn;
    av = 0; bv = 0;
    for (int i = 2; i >= 0; i--) begin
      an = a[i*4 +: 4];
      bn = b[i*4 +: 4];
      if (an > 9 || bn > 9) return {1'b1, 1'b0, 12'h000};
      av = av * 10 + int'(an);
      bv = bv * 10 + int'(bn);
    end
    m = (av >= bv) ? av - bv : bv - av;
    return {1'b0, av < bv, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  function automatic logic [11:0] rnd_bcd(input bit allow_err);
    logic [11:0] v;
    for (int i = 0; i < 3; i++)
      v[i*4 +: 4] = allow_err ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
    return v;
  endfunction

  task automatic apply_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_cnt = 0;
  endtask

  // One full transaction with res_ready held high; starts with the DUT in IDLE.
  task automatic txn(input bit id, input logic [11:0] a, input logic [11:0] b, output int waits);
    logic [13:0] e;
    e = model(a, b);
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    waits = 0;
    while (waits < 20) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) break;
      waits++;
    end
    chk("accept", 32'(waits < 20), 32'd1);
    chk("other_ready", 32'(id ? req0_ready : req1_ready), 32'd0);
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    chk("calc_busy", 32'(busy), 32'd1);
    chk("calc_no_valid", 32'(res_valid), 32'd0);
    @(posedge clk); #1;
    chk("res_valid", 32'(res_valid), 32'd1);
    chk("res_diff", 32'(res_diff), 32'(e[11:0]));
    chk("res_negative", 32'(res_negative), 32'(e[12]));
    chk("res_error", 32'(res_error), 32'(e[13]));
    chk("res_id", 32'(res_id), 32'(id));
    exp_cnt++;
    @(posedge clk); #1;
    chk("consumed", 32'(res_valid), 32'd0);
    chk("op_count", 32'(op_count), 32'(exp_cnt));
  endtask

  initial begin
    int w;
    logic [13:0] e;
    logic [11:0] snap_diff;
    logic        snap_neg, snap_id, snap_err;

    // Reset state
    #2;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_res_diff", 32'(res_diff), 32'd0);
    chk("rst_res_neg", 32'(res_negative), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_res_err", 32'(res_error), 32'd0);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    apply_reset();

    // Directed cases
    txn(1'b0, 12'h123, 12'h045, w);
    chk("first_idle_ready", 32'(w), 32'd0);
    txn(1'b1, 12'h045, 12'h123, w);
    txn(1'b0, 12'h500, 12'h500, w);
    txn(1'b0, 12'h1A3, 12'h001, w);
    txn(1'b1, 12'h999, 12'h000, w);
    txn(1'b1, 12'h000, 12'h999, w);
    txn(1'b0, 12'h100, 12'h001, w);

    // Random transactions
    for (int n = 0; n < 40; n++)
      txn(1'($urandom_range(0, 1)), rnd_bcd($urandom_range(0, 5) == 0),
          rnd_bcd($urandom_range(0, 5) == 0), w);

    // Round-robin under continuous contention
    apply_reset();
    res_ready = 1'b1;
    req0_a = 12'h321; req0_b = 12'h100;
    req1_a = 12'h100; req1_b = 12'h321;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (w < 20) begin
        @(negedge clk);
        if (req0_ready || req1_ready) break;
        w++;
      end
      chk("rr_accept", 32'(w < 20), 32'd1);
      chk("rr_not_both", 32'(req0_ready && req1_ready), 32'd0);
      chk("rr_order", 32'(req1_ready), 32'(k % 2));
      @(negedge clk);
      chk("rr_calc_ready", 32'({req0_ready, req1_ready}), 32'd0);
      @(negedge clk);
      chk("rr_hold_ready", 32'({req0_ready, req1_ready}), 32'd0);
      chk("rr_res_id", 32'(res_id), 32'(k % 2));
      chk("rr_res_neg", 32'(res_negative), 32'(k % 2));
      chk("rr_res_diff", 32'(res_diff), 32'h221);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    chk("rr_op_count", 32'(op_count), 32'd4);

    // Hold with back-pressure, then asynchronous reset mid-HOLD
    apply_reset();
    txn(1'b0, 12'h050, 12'h049, w);
    res_ready = 1'b0;
    req0_a = 12'h007; req0_b = 12'h912;
    req1_a = 12'h640; req1_b = 12'h385;
    req0_valid = 1'b1; req1_valid = 1'b1;
    e = model(12'h640, 12'h385);
    w = 0;
    while (w < 20) begin
      @(negedge clk);
      if (req0_ready || req1_ready) break;
      w++;
    end
    chk("hold_accept", 32'(w < 20), 32'd1);
    chk("hold_grant1", 32'(req1_ready), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("hold_res_diff", 32'(res_diff), 32'(e[11:0]));
    chk("hold_res_neg", 32'(res_negative), 32'(e[12]));
    snap_diff = res_diff; snap_neg = res_negative; snap_id = res_id; snap_err = res_error;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_stable", 32'({snap_err, snap_id, snap_neg, snap_diff}),
          32'({res_error, res_id, res_negative, res_diff}));
      chk("hold_no_ready", 32'({req0_ready, req1_ready}), 32'd0);
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_op_count", 32'(op_count), 32'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_res_valid", 32'(res_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_op_count", 32'(op_count), 32'd0);
    chk("arst_res_diff", 32'(res_diff), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(res_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
